endian_swap_stage: RTL
======================

Name: endian_swap_stage

Overview:
Parametrised, streaming lane-permutation stage that generalises the fixed 32-bit byte-reverse.
- Selects pass-through, lane reverse, half swap or bit reverse per beat.
- Data width and lane width are parametrised.
- Sits between the load/store data path and memory-side logic.
- Output is buffered through a 2-entry valid/ready queue, so the ready path is registered and full throughput is sustained.

Parameters:
- DATA_W, 32: data width in bits. Must be a multiple of 2*LANE_W.
- LANE_W, 8: lane width in bits for lane-reverse mode.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_mode  in  2  permutation mode, sampled with the beat
- in_data  in  DATA_W  input word
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat
- out_data  out  DATA_W  permuted word
- out_mode  out  2  mode the beat was permuted with

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready at a rising clk edge.
  - Output transfer occurs when out_valid && out_ready at a rising clk edge.
- Mode encoding:
  - 00 PASS: out = in.
  - 01 LANE_REV: lane k of out = lane (N-1-k) of in, where N = DATA_W/LANE_W. With defaults this is a byte reverse.
  - 10 HALF_SWAP: out = {in[DATA_W/2-1:0], in[DATA_W-1:DATA_W/2]}.
  - 11 BIT_REV: out[i] = in[DATA_W-1-i].
- Permutation is combinational on in_data/in_mode. The permuted word and the mode are written into the queue.
- Queue:
  - 2 entries, occupancy count 0..2, plus wr_ptr and rd_ptr, 1 bit each. Both pointers wrap 1->0.
  - in_ready = (count != 2), decoded from the registered count only. No combinational path from out_ready.
  - out_valid = (count != 0).
  - out_data/out_mode always show the entry at rd_ptr.
- Latency: a beat accepted at edge N is presented on out_data after edge N (1 cycle) when the queue was empty.
- Simultaneous push and pop:
  - At count 1: count stays 1, both pointers advance, throughput is 1 beat/cycle.
  - At count 2: no push is possible because in_ready=0. A pop gives count 1.
  - At count 0: only a push can occur. Out_valid is 0, so there is no pop.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- Backpressure:
  - While out_valid && !out_ready, out_data/out_mode are held stable.
  - in_data is ignored when in_ready=0.
- Reset (asynchronous, any time, including mid-stream): count=0, wr_ptr=rd_ptr=0.
- Reset values of outputs:
  - out_valid=0 and in_ready=1.
  - Storage registers are cleared to 0, so out_data=0 and out_mode=00.
  - In-flight beats are discarded.
- Elaboration: DATA_W % (2*LANE_W) != 0 is a configuration error and stops elaboration.

Optional Feature:
Macro ENDIAN_SWAP_STAT_EN.
- When defined:
  - Adds output swap_count [31:0].
  - It increments by 1 on each input transfer whose in_mode != 00.
  - It wraps 0xFFFFFFFF -> 0, and resets to 0.
  - PASS beats are not counted.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package endian_pkg holds:
  - mode constants MODE_PASS=2'b00, MODE_LANE_REV=2'b01, MODE_HALF_SWAP=2'b10, MODE_BIT_REV=2'b11;
  - QUEUE_DEPTH=2.
- One combinational sub-module, lane_permute (parameters DATA_W, LANE_W; ports mode, din, dout). It implements the four permutations with generate loops.
- The top module holds the queue, pointers, count and the optional counter.

Test Plan:
1. Reset, then single beats 0x12345678 in modes 00/01/10/11, with out_ready=1 -> out_data 0x12345678, 0x78563412, 0x56781234, 0x1E6A2C48. Each appears 1 cycle after acceptance, and out_mode matches the mode sent.
2. Back-to-back stream of 8 beats 0x00000001..0x00000008, mode 01, out_ready=1 -> 1 beat/cycle. Outputs are 0x01000000..0x08000000 in order, and in_ready stays 1.
3. Hold out_ready=0 and push 0xAABBCCDD then 0x11223344 (mode 01) -> in_ready=0 after the second push, and out_data holds 0xDDCCBBAA stable. Releasing out_ready -> 0xDDCCBBAA then 0x44332211, and in_ready returns to 1 after the first pop.
4. With count=2, assert reset for one cycle mid-stream -> out_valid=0 and in_ready=1 immediately, out_data=0. The next pushed beat is the first output.
5. Parameter run DATA_W=64, LANE_W=16, mode 01 on 0x0011223344556677 -> 0x6677445522330011. Mode 10 -> 0x4455667700112233.
6. With ENDIAN_SWAP_STAT_EN: push 5 beats with modes 00,01,11,00,10 -> swap_count=3. After reset, swap_count=0.

Source files
------------

// File: rtl/endian_pkg.sv
// rtl/endian_pkg.sv - shared constants for the endian swap stage
// Contents: permutation mode encodings and output queue depth.
package endian_pkg;

    localparam logic [1:0] MODE_PASS      = 2'b00;
    localparam logic [1:0] MODE_LANE_REV  = 2'b01;
    localparam logic [1:0] MODE_HALF_SWAP = 2'b10;
    localparam logic [1:0] MODE_BIT_REV   = 2'b11;

    localparam int QUEUE_DEPTH = 2;

endpackage

// File: rtl/lane_permute.sv
// rtl/lane_permute.sv - combinational word permutation (pass, lane reverse, half swap, bit reverse)
// Ports:
//   mode  in  2       permutation select (endian_pkg MODE_*)
//   din   in  DATA_W  input word
//   dout  out DATA_W  permuted word
module lane_permute
    import endian_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int N_LANES = DATA_W / LANE_W;
    localparam int HALF_W  = DATA_W / 2;

    logic [DATA_W-1:0] lane_rev;
    logic [DATA_W-1:0] half_swap;
    logic [DATA_W-1:0] bit_rev;

    genvar k;
    genvar i;

    generate
        for (k = 0; k < N_LANES; k++) begin : g_lane
            assign lane_rev[k*LANE_W +: LANE_W] = din[(N_LANES-1-k)*LANE_W +: LANE_W];
        end
        for (i = 0; i < DATA_W; i++) begin : g_bit
            assign bit_rev[i] = din[DATA_W-1-i];
        end
    endgenerate

    assign half_swap = {din[HALF_W-1:0], din[DATA_W-1:HALF_W]};

    always_comb begin
        dout = din;
        case (mode)
            MODE_PASS:      dout = din;
            MODE_LANE_REV:  dout = lane_rev;
            MODE_HALF_SWAP: dout = half_swap;
            MODE_BIT_REV:   dout = bit_rev;
            default:        dout = din;
        endcase
    end

endmodule

// File: rtl/endian_swap_stage.sv
// rtl/endian_swap_stage.sv - streaming lane-permutation stage with a 2-entry registered output queue
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready/in_mode/in_data      input beat handshake
//   out_valid/out_ready/out_data/out_mode  output beat handshake
//   swap_count [31:0]                      only when ENDIAN_SWAP_STAT_EN is defined
module endian_swap_stage
    import endian_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_mode
`ifdef ENDIAN_SWAP_STAT_EN
    ,
    output logic [31:0]       swap_count
`endif
);

    generate
        if (DATA_W % (2 * LANE_W) != 0) begin : g_cfg_error
            $error("endian_swap_stage: DATA_W must be a multiple of 2*LANE_W");
        end
    endgenerate

    logic [DATA_W-1:0] perm_data;
    logic [DATA_W-1:0] mem_data [QUEUE_DEPTH];
    logic [1:0]        mem_mode [QUEUE_DEPTH];
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    lane_permute #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_permute (
        .mode (in_mode),
        .din  (in_data),
        .dout (perm_data)
    );

    // Both handshakes decode from the registered count only, so in_ready
    // never depends combinationally on out_ready.
    assign in_ready  = (count != 2'(QUEUE_DEPTH));
    assign out_valid = (count != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_mode  = mem_mode[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_mode[0] <= 2'b00;
            mem_mode[1] <= 2'b00;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= perm_data;
                mem_mode[wr_ptr] <= in_mode;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ENDIAN_SWAP_STAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_count <= 32'd0;
        end else if (push && (in_mode != MODE_PASS)) begin
            swap_count <= swap_count + 32'd1;
        end
    end
`endif

endmodule
